keys_conditioner: RTL and testbench
===================================

KEYS_CONDITIONER -- requirements
Module: keys_conditioner

Interface
REQ-001 SHALL have parameter KEYS_W, default 4: number of independent key channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500000: consecutive stable cycles required to accept a level change; legal range >= 1.
REQ-003 SHALL have parameter REPEAT_DELAY, default 25000000: held cycles before the first auto-repeat pulse; legal range >= 1.
REQ-004 SHALL have parameter REPEAT_PERIOD, default 5000000: cycles between subsequent auto-repeat pulses; legal range >= 1.
REQ-005 SHALL have port clk_i, input, 1: single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_i, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port keys_i, input, KEYS_W: raw asynchronous key levels, active-high, already polarity-corrected at board level.
REQ-008 SHALL have port keys_o, output, KEYS_W: debounced key levels.
REQ-009 SHALL have port pressed_o, output, KEYS_W: one-cycle pulse per key on accepted 0->1 transition.
REQ-010 SHALL have port released_o, output, KEYS_W: one-cycle pulse per key on accepted 1->0 transition.
REQ-011 SHALL have port repeat_o, output, KEYS_W: one-cycle auto-repeat pulses while a key is held.

Function
REQ-012 Each keys_i bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Each key SHALL have a counter sized $clog2(DEBOUNCE_CYCLES+1); it increments while synced level != keys_o bit and clears to 0 whenever they are equal.
REQ-014 When a counter reaches DEBOUNCE_CYCLES, keys_o bit SHALL toggle next edge and the counter SHALL clear.
REQ-015 Latency: a clean step on keys_i at edge N SHALL appear on keys_o at edge N+2+DEBOUNCE_CYCLES.
REQ-016 A glitch shorter than DEBOUNCE_CYCLES synced cycles SHALL produce no change on any output.
REQ-017 pressed_o/released_o SHALL be asserted in the same cycle keys_o changes, for exactly one cycle.
REQ-018 Channels SHALL be fully independent; simultaneous events on several keys SHALL each produce their own pulses in the same cycle.
REQ-019 Auto-repeat per key SHALL be an FSM with states IDLE, HOLD, REPEAT sharing one counter sized for max(REPEAT_DELAY, REPEAT_PERIOD).
REQ-020 IDLE->HOLD on pressed pulse, counter cleared; HOLD: after REPEAT_DELAY cycles held, pulse repeat_o, go REPEAT, clear counter; REPEAT: pulse repeat_o every REPEAT_PERIOD cycles.
REQ-021 Released pulse from HOLD or REPEAT SHALL return to IDLE same edge with no repeat pulse that cycle; release wins over a coincident repeat expiry.
REQ-022 repeat_o SHALL never coincide with pressed_o for the same key.

Reset
REQ-023 rst_i assertion SHALL asynchronously clear synchronizers, counters, keys_o, pressed_o, released_o, repeat_o to 0 and FSMs to IDLE.
REQ-024 Reset mid-debounce or mid-repeat SHALL discard progress; no pulse SHALL be emitted on reset assertion or deassertion.
REQ-025 A key held through reset deassertion SHALL produce pressed_o DEBOUNCE_CYCLES+2 edges after deassertion.

Configuration
REQ-026 Macro KEYS_AUTOREPEAT_EN defined: REQ-019..REQ-022 implemented as specified.
REQ-027 Macro KEYS_AUTOREPEAT_EN undefined: no repeat FSM or counters synthesized; repeat_o tied to 0; all other behaviour unchanged.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, KEYS_W=4)
REQ-028 keys_i[0] 0->1 at edge 0, held -> keys_o[0]=1 and pressed_o[0]=1 at edge 6 only; other bits stay 0.
REQ-029 keys_i[1] high for 3 cycles then low -> keys_o, pressed_o, released_o stay 0 throughout.
REQ-030 keys_i[2] held high from edge 0 with macro defined -> pressed at 6, repeat_o[2] at 16, 19, 22; drop input and released_o[2] pulses 6 edges after drop, no further repeats.
REQ-031 keys_i=4'b1111 at one edge -> pressed_o=4'b1111 in a single cycle; release all -> released_o=4'b1111 in a single cycle.
REQ-032 rst_i asserted asynchronously mid-REPEAT with key held -> all outputs 0 immediately; after deassertion pressed_o re-fires at edge 6, first repeat at edge 16.
REQ-033 Macro undefined, key held 50 cycles -> repeat_o stays 0; pressed/released timing identical to REQ-028.

Source files
------------

// File: rtl/keys_conditioner.sv
// Per-key synchronizer, debouncer and edge-pulse generator with optional auto-repeat.
// Auto-repeat is built only when KEYS_AUTOREPEAT_EN is defined; otherwise repeat_o is tied low.
module keys_conditioner #(
  parameter int unsigned KEYS_W          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [KEYS_W-1:0] keys_i,
  output logic [KEYS_W-1:0] keys_o,
  output logic [KEYS_W-1:0] pressed_o,
  output logic [KEYS_W-1:0] released_o,
  output logic [KEYS_W-1:0] repeat_o
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("keys_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  logic [KEYS_W-1:0] r_sync1;
  logic [KEYS_W-1:0] r_sync2;
  logic [KEYS_W-1:0] w_press;
  logic [KEYS_W-1:0] w_rel;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= keys_i;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < KEYS_W; g++) begin : g_debounce
    logic [DB_W-1:0] r_cnt;
    logic            w_hit;

    assign w_hit      = (r_cnt == DB_MAX);
    assign w_press[g] = w_hit & ~keys_o[g];
    assign w_rel[g]   = w_hit & keys_o[g];

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_cnt <= '0;
      end else if (w_hit || (r_sync2[g] == keys_o[g])) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + DB_W'(1);
      end
    end
  end

  // Pulses are registered alongside keys_o so they line up with the level change.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      keys_o     <= '0;
      pressed_o  <= '0;
      released_o <= '0;
    end else begin
      keys_o     <= keys_o ^ (w_press | w_rel);
      pressed_o  <= w_press;
      released_o <= w_rel;
    end
  end

`ifdef KEYS_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {StIdle, StHold, StRepeat} rpt_state_e;

  logic [KEYS_W-1:0] w_rep;

  for (genvar g = 0; g < KEYS_W; g++) begin : g_repeat
    rpt_state_e       r_state;
    rpt_state_e       w_state_next;
    logic [RPT_W-1:0] r_rcnt;
    logic [RPT_W-1:0] w_rcnt_next;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_state <= StIdle;
        r_rcnt  <= '0;
      end else begin
        r_state <= w_state_next;
        r_rcnt  <= w_rcnt_next;
      end
    end

    // Release has priority over any expiry in the same cycle.
    always_comb begin
      w_state_next = r_state;
      w_rcnt_next  = r_rcnt + RPT_W'(1);
      case (r_state)
        StIdle: begin
          w_rcnt_next = '0;
          if (w_press[g]) w_state_next = StHold;
        end
        StHold: begin
          if (w_rel[g]) begin
            w_state_next = StIdle;
            w_rcnt_next  = '0;
          end else if (r_rcnt == DELAY_LAST) begin
            w_state_next = StRepeat;
            w_rcnt_next  = '0;
          end
        end
        StRepeat: begin
          if (w_rel[g]) begin
            w_state_next = StIdle;
            w_rcnt_next  = '0;
          end else if (r_rcnt == PERIOD_LAST) begin
            w_rcnt_next = '0;
          end
        end
        default: begin
          w_state_next = StIdle;
          w_rcnt_next  = '0;
        end
      endcase
    end

    always_comb begin
      w_rep[g] = 1'b0;
      if (!w_rel[g]) begin
        w_rep[g] = ((r_state == StHold) && (r_rcnt == DELAY_LAST)) ||
                   ((r_state == StRepeat) && (r_rcnt == PERIOD_LAST));
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      repeat_o <= '0;
    end else begin
      repeat_o <= w_rep;
    end
  end
`else
  assign repeat_o = '0;
`endif

endmodule

// File: tb/tb_keys_conditioner.sv
// Scoreboard bench for keys_conditioner: stimulus schedules expected pulses by edge number,
// a per-cycle monitor pops and compares them. Honours KEYS_AUTOREPEAT_EN like the design.
module tb_keys_conditioner;

  localparam int unsigned W   = 4;
  localparam int unsigned DB  = 4;
  localparam int unsigned RD  = 10;
  localparam int unsigned RP  = 3;
  localparam int unsigned LAT = DB + 2;

  typedef struct {
    int unsigned e;
    logic [W-1:0] p;
    logic [W-1:0] r;
    logic [W-1:0] rp;
  } ev_t;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [W-1:0] keys_i;
  logic [W-1:0] keys_o;
  logic [W-1:0] pressed_o;
  logic [W-1:0] released_o;
  logic [W-1:0] repeat_o;

  int          n_checks = 0;
  int          n_errs   = 0;
  int unsigned cyc      = 0;
  bit          mon_en   = 1'b0;
  ev_t         sb[$];
  ev_t         ev;
  logic [W-1:0] exp_keys = '0;
  logic [W-1:0] ep, er, erp;

  keys_conditioner #(
    .KEYS_W         (W),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) u_dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .keys_i    (keys_i),
    .keys_o    (keys_o),
    .pressed_o (pressed_o),
    .released_o(released_o),
    .repeat_o  (repeat_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic push_ev(input int unsigned e, input logic [W-1:0] p, input logic [W-1:0] r,
                         input logic [W-1:0] rp);
    ev_t x;
    int  i;
    x.e  = e;
    x.p  = p;
    x.r  = r;
    x.rp = rp;
    i    = 0;
    while (i < sb.size() && sb[i].e <= e) i++;
    sb.insert(i, x);
  endtask

  // n / r: edges at which the press / release levels are first sampled.
  task automatic sched(input int unsigned n, input int unsigned r, input logic [W-1:0] m);
    int unsigned t;
    push_ev(n + LAT, m, '0, '0);
    push_ev(r + LAT, '0, m, '0);
`ifdef KEYS_AUTOREPEAT_EN
    t = n + LAT + RD;
    while (t < r + LAT) begin
      push_ev(t, '0, '0, m);
      t += RP;
    end
`else
    t = 0;
`endif
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic hold_key(input logic [W-1:0] m, input int unsigned hold, input int unsigned gap);
    int unsigned n;
    tick();
    keys_i = keys_i | m;
    n      = cyc + 1;
    sched(n, n + hold, m);
    repeat (hold) tick();
    keys_i = keys_i & ~m;
    repeat (gap) tick();
  endtask

  always @(posedge clk_i) begin
    #1;
    if (mon_en) begin
      ep  = '0;
      er  = '0;
      erp = '0;
      while (sb.size() > 0 && sb[0].e <= cyc) begin
        ev = sb.pop_front();
        if (ev.e < cyc) chk("sb_stale_event", ev.e, cyc);
        ep  = ep | ev.p;
        er  = er | ev.r;
        erp = erp | ev.rp;
      end
      exp_keys = (exp_keys | ep) & ~er;
      chk("keys_o", keys_o, exp_keys);
      chk("pressed_o", pressed_o, ep);
      chk("released_o", released_o, er);
      chk("repeat_o", repeat_o, erp);
    end
  end

  initial begin
    int unsigned n;
    rst_i  = 1'b1;
    keys_i = '0;
    repeat (3) tick();
    chk("rst_keys_o", keys_o, '0);
    chk("rst_pressed_o", pressed_o, '0);
    chk("rst_released_o", released_o, '0);
    chk("rst_repeat_o", repeat_o, '0);
    rst_i  = 1'b0;
    mon_en = 1'b1;
    repeat (3) tick();

    hold_key(4'b0001, 50, 12);   // single clean press, long hold
    tick();                      // glitch of 3 synced cycles: no events
    keys_i = 4'b0010;
    repeat (3) tick();
    keys_i = 4'b0000;
    repeat (15) tick();
    hold_key(4'b0100, 25, 12);   // release coincides with a repeat expiry
    hold_key(4'b1111, 12, 12);   // all channels together

    // Asynchronous reset while key 3 is in the repeat phase.
    tick();
    keys_i = 4'b1000;
    n      = cyc + 1;
    sched(n, n + 1000, 4'b1000);
    repeat (22) tick();
    #2;
    rst_i  = 1'b1;
    mon_en = 1'b0;
    #1;
    chk("async_rst_keys_o", keys_o, '0);
    chk("async_rst_pressed_o", pressed_o, '0);
    chk("async_rst_released_o", released_o, '0);
    chk("async_rst_repeat_o", repeat_o, '0);
    sb.delete();
    exp_keys = '0;
    repeat (3) tick();
    rst_i  = 1'b0;
    mon_en = 1'b1;
    // First edge with reset released samples the still-held key.
    n = cyc + 1;
    sched(n, n + 30, 4'b1000);
    repeat (30) tick();
    keys_i = 4'b0000;
    repeat (15) tick();

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
